// File: rtl/rtype_issue_ctrl.sv
// rtype_issue_ctrl
//   R-type function decode with register-jump write gating, plus a multi-cycle
//   MULT/DIV sequencer that owns the HI/LO write and interlocks dependent issues.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   issue_valid, rtype_i          instruction present / is R-type
//   reg_write_i, reg_write2_i     GPR / HI-LO write requests from main controller
//   fnctn[FN_W-1:0]               function field
//   rtype, reg_write, jr          decode outputs (combinational)
//   stall, muldiv_start           interlock and start pulse (combinational)
//   muldiv_op[1:0]                latched op: 0 mult, 1 multu, 2 div, 3 divu
//   busy, reg_write2              sequencer active / HI-LO write in DONE
module rtype_issue_ctrl #(
    parameter int unsigned FN_W     = 6,
    parameter int unsigned MULT_LAT = 4,
    parameter int unsigned DIV_LAT  = 32,
    parameter int unsigned CNT_W    = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic            rtype_i,
    input  logic            reg_write_i,
    input  logic            reg_write2_i,
    input  logic [FN_W-1:0] fnctn,
    output logic            rtype,
    output logic            reg_write,
    output logic            jr,
    output logic            stall,
    output logic            muldiv_start,
    output logic [1:0]      muldiv_op,
    output logic            busy,
    output logic            reg_write2
);

    localparam logic [FN_W-1:0] FN_JR   = FN_W'(6'b001000);
    localparam logic [FN_W-1:0] FN_JALR = FN_W'(6'b001001);
    localparam logic [FN_W-1:0] FN_MFHI = FN_W'(6'b010000);
    localparam logic [FN_W-1:0] FN_MFLO = FN_W'(6'b010010);
    // MULT/MULTU/DIV/DIVU share 0110xx; low two bits are the op encoding.
    localparam logic [FN_W-1:0] FN_MD_HI = FN_W'(6'b000110);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]       r_op, w_op_nxt;
    logic             r_hilo_req, w_hilo_nxt;

    logic w_is_jr, w_is_jalr, w_is_mfhilo, w_is_md, w_go;

    // Full-width compares so nonzero bits above bit 5 never match a code.
    assign w_is_jr     = (fnctn == FN_JR);
    assign w_is_jalr   = (fnctn == FN_JALR);
    assign w_is_mfhilo = (fnctn == FN_MFHI) || (fnctn == FN_MFLO);
    assign w_is_md     = ((fnctn >> 2) == FN_MD_HI);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_op       <= 2'd0;
            r_hilo_req <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_op       <= w_op_nxt;
            r_hilo_req <= w_hilo_nxt;
        end
    end

    // Interlock, decode and sequencer next-state
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_op_nxt     = r_op;
        w_hilo_nxt   = r_hilo_req;
        rtype        = 1'b0;
        reg_write    = 1'b0;
        jr           = 1'b0;
        muldiv_start = 1'b0;

        // Comb outputs are forced low while reset is held.
        stall = ~rst & issue_valid & rtype_i & (r_state != ST_IDLE)
              & (w_is_mfhilo | w_is_md);
        w_go  = ~rst & issue_valid & rtype_i & ~stall;

        case (r_state)
            ST_BUSY: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: ;
        endcase

        if (w_go) begin
            if (w_is_jr) begin
                jr = 1'b1;
            end else if (w_is_jalr) begin
                jr        = 1'b1;
                rtype     = 1'b1;
                reg_write = reg_write_i;
            end else if (w_is_md) begin
                // Only reachable in IDLE: any other state stalls MULT/DIV.
                muldiv_start = 1'b1;
                w_op_nxt     = fnctn[1:0];
                w_hilo_nxt   = reg_write2_i;
                w_cnt_nxt    = fnctn[1] ? CNT_W'(DIV_LAT - 1) : CNT_W'(MULT_LAT - 1);
                w_state_nxt  = ST_BUSY;
            end else begin
                rtype     = 1'b1;
                reg_write = reg_write_i;
            end
        end
    end

    assign muldiv_op  = r_op;
    assign busy       = (r_state != ST_IDLE);
    assign reg_write2 = (r_state == ST_DONE) & r_hilo_req;

endmodule

// File: tb/tb_rtype_issue_ctrl.sv
// tb_rtype_issue_ctrl
//   Random and directed stimulus against a cycle-numbered reference model:
//   an accepted MULT/DIV at cycle t is busy over t+1..t+LAT+1 and writes
//   HI/LO at t+LAT+1.
module tb_rtype_issue_ctrl;

    localparam int unsigned FN_W     = 8;
    localparam int unsigned MULT_LAT = 4;
    localparam int unsigned DIV_LAT  = 32;
    localparam int unsigned CNT_W    = 6;

    localparam logic [5:0] C_JR   = 6'b001000;
    localparam logic [5:0] C_JALR = 6'b001001;
    localparam logic [5:0] C_MFHI = 6'b010000;
    localparam logic [5:0] C_MFLO = 6'b010010;
    localparam logic [5:0] C_MULT = 6'b011000;
    localparam logic [5:0] C_DIV  = 6'b011010;
    localparam logic [5:0] C_ADD  = 6'b100000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic issue_valid = 1'b0, rtype_i = 1'b0, reg_write_i = 1'b0, reg_write2_i = 1'b0;
    logic [FN_W-1:0] fnctn = '0;
    logic rtype, reg_write, jr, stall, muldiv_start, busy, reg_write2;
    logic [1:0] muldiv_op;

    rtype_issue_ctrl #(
        .FN_W(FN_W), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .rtype_i(rtype_i),
        .reg_write_i(reg_write_i), .reg_write2_i(reg_write2_i),
        .fnctn(fnctn),
        .rtype(rtype), .reg_write(reg_write), .jr(jr), .stall(stall),
        .muldiv_start(muldiv_start), .muldiv_op(muldiv_op),
        .busy(busy), .reg_write2(reg_write2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model state: one in-flight operation described by cycle numbers.
    bit       m_active = 0;
    int       m_acc    = 0;
    int       m_lat    = 0;
    bit [1:0] m_op     = 0;
    bit       m_hilo   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", tag, cyc, obs, exp_v);
        end
    endtask

    // One clock cycle: drive inputs, predict, compare every output, advance model.
    task automatic step(input logic v, input logic rt, input logic rw, input logic rw2,
                        input logic [FN_W-1:0] fn, input logic r);
        bit [5:0] lo;
        bit hi_ok, c_jr, c_jalr, c_mf, c_md;
        bit e_busy, e_done, e_stall, e_go;
        bit e_jr, e_rtype, e_rw, e_start, e_rw2;
        @(posedge clk);
        #1;
        issue_valid = v; rtype_i = rt; reg_write_i = rw; reg_write2_i = rw2;
        fnctn = fn; rst = r;
        #1;
        lo     = fn[5:0];
        hi_ok  = (fn[FN_W-1:6] == '0);
        c_jr   = hi_ok && lo == C_JR;
        c_jalr = hi_ok && lo == C_JALR;
        c_mf   = hi_ok && (lo == C_MFHI || lo == C_MFLO);
        c_md   = hi_ok && lo[5:2] == 4'b0110;
        if (r) begin
            m_active = 0;
            m_op     = 0;
            e_busy = 0; e_done = 0; e_stall = 0; e_go = 0;
        end else begin
            e_busy  = m_active && cyc > m_acc && cyc <= m_acc + m_lat + 1;
            e_done  = m_active && cyc == m_acc + m_lat + 1;
            e_stall = v && rt && e_busy && (c_mf || c_md);
            e_go    = v && rt && !e_stall;
        end
        e_jr    = e_go && (c_jr || c_jalr);
        e_rtype = e_go && !c_jr && !c_md;
        e_rw    = e_go && !c_jr && !c_md && rw;
        e_start = e_go && c_md;
        e_rw2   = e_done && m_hilo;
        check("stall",        32'(stall),        32'(e_stall));
        check("jr",           32'(jr),           32'(e_jr));
        check("rtype",        32'(rtype),        32'(e_rtype));
        check("reg_write",    32'(reg_write),    32'(e_rw));
        check("muldiv_start", 32'(muldiv_start), 32'(e_start));
        check("muldiv_op",    32'(muldiv_op),    32'(m_op));
        check("busy",         32'(busy),         32'(e_busy));
        check("reg_write2",   32'(reg_write2),   32'(e_rw2));
        check("jr_and_start", 32'(jr & muldiv_start), 32'(0));
        if (e_start) begin
            m_active = 1;
            m_acc    = cyc;
            m_lat    = lo[1] ? DIV_LAT : MULT_LAT;
            m_op     = lo[1:0];
            m_hilo   = rw2;
        end else if (m_active && cyc >= m_acc + m_lat + 1) begin
            m_active = 0;
        end
        cyc++;
    endtask

    function automatic logic [FN_W-1:0] fx(input logic [5:0] c);
        return FN_W'(c);
    endfunction

    initial begin
        int busy_cnt, rw2_cnt, rw2_at, stalls;
        logic [FN_W-1:0] fn;
        logic [5:0] codes [10];

        step(0, 0, 0, 0, '0, 1);
        step(0, 0, 0, 0, '0, 1);
        step(0, 0, 0, 0, '0, 0);

        // JR gates the write; JALR keeps the link write; ADD is a plain R-type.
        step(1, 1, 1, 0, fx(C_JR), 0);
        check("t1_jr", 32'({jr, rtype, reg_write}), 32'(3'b100));
        step(1, 1, 1, 0, fx(C_JALR), 0);
        check("t2_jalr", 32'({jr, rtype, reg_write}), 32'(3'b111));
        step(1, 1, 1, 0, fx(C_ADD), 0);
        check("t2_add", 32'({jr, rtype, reg_write}), 32'(3'b011));
        step(1, 1, 1, 0, {2'b01, C_JR}, 0);
        check("upper_bits", 32'({jr, rtype}), 32'(2'b01));

        // MULT with HI/LO write: busy five cycles, one write on the last.
        step(1, 1, 0, 1, fx(C_MULT), 0);
        check("t3_start", 32'(muldiv_start), 32'(1));
        busy_cnt = 0; rw2_cnt = 0; rw2_at = 0;
        for (int i = 1; i <= 7; i++) begin
            step(0, 0, 0, 0, '0, 0);
            if (busy) busy_cnt++;
            if (reg_write2) begin rw2_cnt++; rw2_at = i; end
        end
        check("t3_busy_cycles", 32'(busy_cnt), 32'(5));
        check("t3_rw2_pulses", 32'(rw2_cnt), 32'(1));
        check("t3_rw2_offset", 32'(rw2_at), 32'(5));

        // DIV then MFLO: 33 stalled cycles, issues on the 34th.
        step(1, 1, 0, 1, fx(C_DIV), 0);
        stalls = 0;
        for (int i = 0; i < 100; i++) begin
            step(1, 1, 1, 0, fx(C_MFLO), 0);
            if (!stall) break;
            stalls++;
        end
        check("t4_mflo_stalls", 32'(stalls), 32'(33));
        check("t4_mflo_issue", 32'(rtype), 32'(1));

        // ADD during BUSY is not stalled; back-to-back MULT waits for IDLE.
        step(1, 1, 0, 0, fx(C_MULT), 0);
        step(1, 1, 1, 0, fx(C_ADD), 0);
        check("t4_add_busy", 32'({stall, rtype, busy}), 32'(3'b011));
        stalls = 0;
        for (int i = 0; i < 100; i++) begin
            step(1, 1, 0, 0, fx(C_MULT), 0);
            if (!stall) break;
            stalls++;
        end
        check("t5_mult_stalls", 32'(stalls), 32'(4));
        check("t5_restart", 32'(muldiv_start), 32'(1));

        // Reset mid-BUSY aborts the operation without a HI/LO write.
        step(0, 0, 0, 0, '0, 0);
        step(0, 0, 0, 0, '0, 1);
        check("t6_rst_busy", 32'({busy, stall}), 32'(0));
        rw2_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 0, '0, 0);
            if (reg_write2) rw2_cnt++;
        end
        check("t6_no_rw2", 32'(rw2_cnt), 32'(0));

        codes = '{C_JR, C_JALR, C_MFHI, C_MFLO, 6'b011000, 6'b011001,
                  6'b011010, 6'b011011, C_ADD, 6'b100011};
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) fn = FN_W'($urandom);
            else fn = FN_W'(codes[$urandom_range(0, 9)]);
            if ($urandom_range(0, 15) == 0) fn[FN_W-1:6] = 2'($urandom_range(1, 3));
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) != 0),
                 1'($urandom), 1'($urandom), fn, ($urandom_range(0, 299) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
